// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and data requests share one memory
// with a fixed read latency; one transaction in flight, data preferred unless fetch starves.
module mem_arbiter #(
  parameter int LAT      = 2,
  parameter int MAX_WAIT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_en,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic [15:0] conflict_cnt
);

  localparam logic [2:0] LAT_LOAD    = 3'(LAT - 1);
  localparam logic [2:0] WAIT_LIMIT  = 3'(MAX_WAIT);
  localparam logic       OWNER_DATA  = 1'b0;
  localparam logic       OWNER_FETCH = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic [2:0]  lat_cnt_q, lat_cnt_d;
  logic [2:0]  fetch_wait_q, fetch_wait_d;
  logic [15:0] conflict_cnt_q, conflict_cnt_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        grant_fetch, grant_data, busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      owner_q        <= OWNER_DATA;
      we_q           <= 1'b0;
      lat_cnt_q      <= 3'd0;
      fetch_wait_q   <= 3'd0;
      conflict_cnt_q <= 16'd0;
      if_rdata_q     <= 32'd0;
      d_rdata_q      <= 32'd0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      we_q           <= we_d;
      lat_cnt_q      <= lat_cnt_d;
      fetch_wait_q   <= fetch_wait_d;
      conflict_cnt_q <= conflict_cnt_d;
      if_rdata_q     <= if_rdata_d;
      d_rdata_q      <= d_rdata_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    we_d           = we_q;
    lat_cnt_d      = lat_cnt_q;
    fetch_wait_d   = fetch_wait_q;
    conflict_cnt_d = conflict_cnt_q;
    if_rdata_d     = if_rdata_q;
    d_rdata_d      = d_rdata_q;
    grant_fetch    = 1'b0;
    grant_data     = 1'b0;
    if_gnt         = 1'b0;
    d_gnt          = 1'b0;
    if_rvalid      = 1'b0;
    d_rvalid       = 1'b0;
    m_en           = 1'b0;
    m_we           = 1'b0;
    m_addr         = 32'd0;
    m_wdata        = 32'd0;

    // Grant decisions are masked while reset is held so no output leaks through.
    case (state_q)
      IDLE: begin
        if (rst_n) begin
          if (if_req && d_req) begin
            if (conflict_cnt_q != 16'hFFFF) conflict_cnt_d = conflict_cnt_q + 16'd1;
            if (fetch_wait_q >= WAIT_LIMIT) grant_fetch = 1'b1;
            else                            grant_data  = 1'b1;
          end else if (if_req) begin
            grant_fetch = 1'b1;
          end else if (d_req) begin
            grant_data = 1'b1;
          end
        end
      end
      WAIT: begin
        if (lat_cnt_q == 3'd0) begin
          state_d = RESP;
          if (owner_q == OWNER_FETCH) if_rdata_d = m_rdata;
          else                        d_rdata_d  = we_q ? 32'd0 : m_rdata;
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (owner_q == OWNER_FETCH) if_rvalid = 1'b1;
        else                        d_rvalid  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (grant_fetch) begin
      if_gnt    = 1'b1;
      m_en      = 1'b1;
      m_addr    = if_addr;
      owner_d   = OWNER_FETCH;
      we_d      = 1'b0;
      lat_cnt_d = LAT_LOAD;
      state_d   = WAIT;
    end else if (grant_data) begin
      d_gnt     = 1'b1;
      m_en      = 1'b1;
      m_we      = d_we;
      m_addr    = d_addr;
      m_wdata   = d_wdata;
      owner_d   = OWNER_DATA;
      we_d      = d_we;
      lat_cnt_d = LAT_LOAD;
      state_d   = WAIT;
    end

    if (if_gnt)                                  fetch_wait_d = 3'd0;
    else if (if_req && fetch_wait_q != 3'd7)     fetch_wait_d = fetch_wait_q + 3'd1;

    busy      = (state_q != IDLE);
    stall_if  = rst_n && ((if_req && !if_gnt) ||
                          (owner_q == OWNER_FETCH && busy && !if_rvalid));
    stall_mem = rst_n && ((d_req && !d_gnt) ||
                          (owner_q == OWNER_DATA && busy && !d_rvalid));
  end

  assign if_rdata     = if_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (LAT=2, MAX_WAIT=3): fetch/data reads, writes,
// arbitration with starvation guard, counter saturation and mid-transaction reset.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        m_en;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        stall_if;
  logic        stall_mem;
  logic [15:0] conflict_cnt;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.LAT(2), .MAX_WAIT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .stall_if(stall_if), .stall_mem(stall_mem),
    .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One call = one clock cycle: inputs change on the falling edge, checks follow 1 unit later.
  task automatic applyStimulus(input logic rst, input logic ir, input logic [31:0] ia,
                               input logic dr, input logic dwe, input logic [31:0] da,
                               input logic [31:0] dwd);
    @(negedge clk);
    rst_n   = rst;
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_we    = dwe;
    d_addr  = da;
    d_wdata = dwd;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = 32'd0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 32'd0; d_wdata = 32'd0; m_rdata = 32'd0;

    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("rst_m_en", m_en, 0);
    checkOutput("rst_if_gnt", if_gnt, 0);
    checkOutput("rst_d_gnt", d_gnt, 0);
    checkOutput("rst_if_rvalid", if_rvalid, 0);
    checkOutput("rst_d_rvalid", d_rvalid, 0);
    checkOutput("rst_stall_if", stall_if, 0);
    checkOutput("rst_stall_mem", stall_mem, 0);
    checkOutput("rst_conflict", conflict_cnt, 0);
    checkOutput("rst_if_rdata", if_rdata, 0);
    checkOutput("rst_d_rdata", d_rdata, 0);
    idleCycles(1);
    checkOutput("idle_m_en", m_en, 0);

    // Single fetch read
    m_rdata = 32'h8C010004;
    applyStimulus(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("f_if_gnt", if_gnt, 1);
    checkOutput("f_m_en", m_en, 1);
    checkOutput("f_m_addr", m_addr, 32'h40);
    checkOutput("f_m_we", m_we, 0);
    checkOutput("f_d_gnt", d_gnt, 0);
    idleCycles(1);
    checkOutput("f_c1_m_en", m_en, 0);
    checkOutput("f_c1_m_addr", m_addr, 0);
    checkOutput("f_c1_stall_if", stall_if, 1);
    checkOutput("f_c1_rvalid", if_rvalid, 0);
    idleCycles(1);
    checkOutput("f_c2_stall_if", stall_if, 1);
    checkOutput("f_c2_rvalid", if_rvalid, 0);
    idleCycles(1);
    checkOutput("f_c3_rvalid", if_rvalid, 1);
    checkOutput("f_c3_rdata", if_rdata, 32'h8C010004);
    checkOutput("f_c3_stall_if", stall_if, 0);
    checkOutput("f_c3_d_rvalid", d_rvalid, 0);
    idleCycles(1);
    checkOutput("f_c4_rvalid", if_rvalid, 0);
    checkOutput("f_c4_rdata_hold", if_rdata, 32'h8C010004);

    // Simultaneous fetch and data read: data wins first
    m_rdata = 32'h11112222;
    applyStimulus(1'b1, 1'b1, 32'h80, 1'b1, 1'b0, 32'h100, 32'd0);
    checkOutput("c_d_gnt", d_gnt, 1);
    checkOutput("c_if_gnt", if_gnt, 0);
    checkOutput("c_m_addr", m_addr, 32'h100);
    checkOutput("c_stall_if", stall_if, 1);
    applyStimulus(1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("c_c1_conflict", conflict_cnt, 1);
    checkOutput("c_c1_stall_if", stall_if, 1);
    checkOutput("c_c1_stall_mem", stall_mem, 1);
    applyStimulus(1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("c_c2_stall_if", stall_if, 1);
    applyStimulus(1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("c_c3_d_rvalid", d_rvalid, 1);
    checkOutput("c_c3_d_rdata", d_rdata, 32'h11112222);
    checkOutput("c_c3_stall_if", stall_if, 1);
    checkOutput("c_c3_stall_mem", stall_mem, 0);
    checkOutput("c_c3_if_rdata_hold", if_rdata, 32'h8C010004);
    applyStimulus(1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("c_c4_if_gnt", if_gnt, 1);
    checkOutput("c_c4_m_addr", m_addr, 32'h80);
    idleCycles(1);
    checkOutput("c_c5_stall_if", stall_if, 1);
    idleCycles(2);
    checkOutput("c_c7_if_rvalid", if_rvalid, 1);
    checkOutput("c_c7_if_rdata", if_rdata, 32'h11112222);
    idleCycles(1);

    // Data write
    m_rdata = 32'h55AA55AA;
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'h20, 32'hDEADBEEF);
    checkOutput("w_d_gnt", d_gnt, 1);
    checkOutput("w_m_en", m_en, 1);
    checkOutput("w_m_we", m_we, 1);
    checkOutput("w_m_addr", m_addr, 32'h20);
    checkOutput("w_m_wdata", m_wdata, 32'hDEADBEEF);
    idleCycles(1);
    checkOutput("w_c1_m_wdata", m_wdata, 0);
    checkOutput("w_c1_m_we", m_we, 0);
    idleCycles(1);
    checkOutput("w_c2_d_rvalid", d_rvalid, 0);
    idleCycles(1);
    checkOutput("w_c3_d_rvalid", d_rvalid, 1);
    checkOutput("w_c3_d_rdata", d_rdata, 0);
    idleCycles(1);

    // Both held: fetch wins once starved, then its wait count is cleared
    applyStimulus(1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 32'h200, 32'd0);
    checkOutput("s_c0_d_gnt", d_gnt, 1);
    checkOutput("s_c0_if_gnt", if_gnt, 0);
    applyStimulus(1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 32'h200, 32'd0);
    checkOutput("s_c1_conflict", conflict_cnt, 2);
    applyStimulus(1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 32'h200, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 32'h200, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 32'h200, 32'd0);
    checkOutput("s_c4_if_gnt", if_gnt, 1);
    checkOutput("s_c4_d_gnt", d_gnt, 0);
    checkOutput("s_c4_m_addr", m_addr, 32'h300);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'h200, 32'd0);
    checkOutput("s_c5_conflict", conflict_cnt, 3);
    checkOutput("s_c5_stall_mem", stall_mem, 1);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'h200, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'h200, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 32'h200, 32'd0);
    checkOutput("s_c8_d_gnt", d_gnt, 1);
    checkOutput("s_c8_if_gnt", if_gnt, 0);
    idleCycles(1);
    checkOutput("s_c9_conflict", conflict_cnt, 4);
    idleCycles(3);

    // Conflict counter saturation
    @(negedge clk);
    force dut.conflict_cnt_q = 16'hFFFE;
    #1;
    release dut.conflict_cnt_q;
    checkOutput("sat_preload", conflict_cnt, 16'hFFFE);
    applyStimulus(1'b1, 1'b1, 32'h400, 1'b1, 1'b0, 32'h500, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h400, 1'b1, 1'b0, 32'h500, 32'd0);
    checkOutput("sat_first", conflict_cnt, 16'hFFFF);
    applyStimulus(1'b1, 1'b1, 32'h400, 1'b1, 1'b0, 32'h500, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h400, 1'b1, 1'b0, 32'h500, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h400, 1'b1, 1'b0, 32'h500, 32'd0);
    idleCycles(1);
    checkOutput("sat_second", conflict_cnt, 16'hFFFF);
    idleCycles(3);

    // Reset during WAIT aborts the fetch
    m_rdata = 32'hCAFEF00D;
    applyStimulus(1'b1, 1'b1, 32'h44, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("r_c0_if_gnt", if_gnt, 1);
    applyStimulus(1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("r_c1_if_gnt", if_gnt, 0);
    checkOutput("r_c1_m_en", m_en, 0);
    checkOutput("r_c1_m_addr", m_addr, 0);
    checkOutput("r_c1_stall_if", stall_if, 0);
    checkOutput("r_c1_if_rdata", if_rdata, 0);
    checkOutput("r_c1_conflict", conflict_cnt, 0);
    applyStimulus(1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("r_c2_m_en", m_en, 0);
    applyStimulus(1'b1, 1'b1, 32'h48, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("r_c3_if_gnt", if_gnt, 1);
    checkOutput("r_c3_m_addr", m_addr, 32'h48);
    checkOutput("r_c3_if_rvalid", if_rvalid, 0);
    idleCycles(1);
    checkOutput("r_c4_if_rvalid", if_rvalid, 0);
    idleCycles(1);
    checkOutput("r_c5_if_rvalid", if_rvalid, 0);
    idleCycles(1);
    checkOutput("r_c6_if_rvalid", if_rvalid, 1);
    checkOutput("r_c6_if_rdata", if_rdata, 32'hCAFEF00D);
    idleCycles(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
